// File: rtl/riscv_trace_pkg.sv
// Shared types for the RISC-V commit-trace monitor: record kinds, status codes,
// FSM states and the packed commit record.
package riscv_trace_pkg;

   localparam logic [1:0] TK_PLAIN = 2'd0;
   localparam logic [1:0] TK_REG   = 2'd1;
   localparam logic [1:0] TK_STORE = 2'd2;
   localparam logic [1:0] TK_BOTH  = 2'd3;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HALT  = 2'd1;
   localparam logic [1:0] ST_HANG  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } trace_rec_t;

   localparam int unsigned REC_W = $bits(trace_rec_t);

   // Builds one commit record; a write to x0 degrades to a plain record.
   function automatic trace_rec_t form_rec(
      input logic [31:0] pc,
      input logic        rf_we,
      input logic [4:0]  rf_wa,
      input logic [31:0] rf_wd,
      input logic        dm_we,
      input logic [31:0] dm_addr,
      input logic [31:0] dm_data
   );
      trace_rec_t r;
      r.kind = {dm_we, rf_we && (rf_wa != 5'd0)};
      r.pc   = pc;
      r.addr = '0;
      r.data = '0;
      if (dm_we) begin
         r.addr = dm_addr;
         r.data = dm_data;
      end else if (r.kind == TK_REG) begin
         r.addr = {27'b0, rf_wa};
         r.data = rf_wd;
      end
      return r;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record buffer with extra-bit full/empty, optional overwrite-oldest
// mode and a sticky overflow flag.
module trace_fifo #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AW        = $clog2(DEPTH),
   parameter int unsigned W         = 8,
   parameter int unsigned OVERWRITE = 0
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         overflow
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         empty_c;
   logic         full_c;
   logic         pop_c;
   logic         wr_en_c;

   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_c   = !empty_c && pop_ready;
   // A full buffer still accepts when a pop frees the slot or in overwrite mode.
   assign wr_en_c = push && (!full_c || pop_c || (OVERWRITE != 0));

   always_ff @(posedge CLK) begin
      if (wr_en_c) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_c || (wr_en_c && full_c)) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (push && full_c && !pop_c) overflow <= 1'b1;
      end
   end

   assign out_valid = !empty_c;
   assign out_data  = empty_c ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/riscv_trace_monitor.sv
// Commit-trace monitor: record formation, cycle/retire counters and halt/hang FSM.
// Optional RISCV_TRACE_FILTER_EN adds FILT_EN to suppress plain records.
module riscv_trace_monitor
   import riscv_trace_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned AW          = $clog2(DEPTH),
   parameter int unsigned HALT_REPEAT = 3,
   parameter int unsigned STALL_LIMIT = 1024,
   parameter int unsigned OVERWRITE   = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RET_VALID,
   input  logic [31:0]      RET_PC,
   input  logic             RF_WE,
   input  logic [4:0]       RF_WA,
   input  logic [31:0]      RF_WD,
   input  logic             DM_WE,
   input  logic [31:0]      DM_ADDR,
   input  logic [31:0]      DM_DATA,
`ifdef RISCV_TRACE_FILTER_EN
   input  logic             FILT_EN,
`endif
   output logic             TR_VALID,
   input  logic             TR_READY,
   output logic [1:0]       TR_KIND,
   output logic [31:0]      TR_PC,
   output logic [31:0]      TR_ADDR,
   output logic [31:0]      TR_DATA,
   output logic [CNT_W-1:0] CYCLE_CNT,
   output logic [CNT_W-1:0] RETIRE_CNT,
   output logic             DONE,
   output logic [1:0]       STATUS,
   output logic             OVERFLOW
);

   localparam int unsigned RPT_W = $clog2(HALT_REPEAT + 1);
   localparam int unsigned IDL_W = $clog2(STALL_LIMIT + 1);

   state_t           state;
   logic [RPT_W-1:0] rep_cnt;
   logic [IDL_W-1:0] idle_cnt;
   logic [31:0]      last_pc;

   trace_rec_t       rec_c;
   trace_rec_t       head;
   logic             accept_c;
   logic             push_c;
   logic [RPT_W-1:0] rep_next_c;
   logic             halt_c;
   logic             hang_c;

   assign rec_c    = form_rec(RET_PC, RF_WE, RF_WA, RF_WD, DM_WE, DM_ADDR, DM_DATA);
   assign accept_c = RET_VALID && (state != S_DONE);
`ifdef RISCV_TRACE_FILTER_EN
   assign push_c   = accept_c && !(FILT_EN && (rec_c.kind == TK_PLAIN));
`else
   assign push_c   = accept_c;
`endif

   // rep_cnt==0 means no previous retire; the first one always starts a run of 1.
   assign rep_next_c = ((rep_cnt != '0) && (RET_PC == last_pc)) ? rep_cnt + RPT_W'(1)
                                                                : RPT_W'(1);
   assign halt_c     = accept_c && (rep_next_c == RPT_W'(HALT_REPEAT));
   assign hang_c     = (state == S_RUN) && (idle_cnt == IDL_W'(STALL_LIMIT));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         STATUS     <= ST_RUN;
         DONE       <= 1'b0;
         CYCLE_CNT  <= '0;
         RETIRE_CNT <= '0;
         rep_cnt    <= '0;
         idle_cnt   <= '0;
         last_pc    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept_c) begin
                  RETIRE_CNT <= RETIRE_CNT + CNT_W'(1);
                  last_pc    <= RET_PC;
                  rep_cnt    <= rep_next_c;
                  if (halt_c) begin
                     state  <= S_DONE;
                     STATUS <= ST_HALT;
                     DONE   <= 1'b1;
                  end else begin
                     state  <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (CYCLE_CNT != {CNT_W{1'b1}}) CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
               if (accept_c) begin
                  if (RETIRE_CNT != {CNT_W{1'b1}}) RETIRE_CNT <= RETIRE_CNT + CNT_W'(1);
                  last_pc  <= RET_PC;
                  rep_cnt  <= rep_next_c;
                  idle_cnt <= '0;
               end else if (idle_cnt != IDL_W'(STALL_LIMIT)) begin
                  idle_cnt <= idle_cnt + IDL_W'(1);
               end
               // Halt takes priority over a hang detected in the same cycle.
               if (halt_c) begin
                  state  <= S_DONE;
                  STATUS <= ST_HALT;
                  DONE   <= 1'b1;
               end else if (hang_c) begin
                  state  <= S_DONE;
                  STATUS <= ST_HANG;
                  DONE   <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   trace_fifo #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .W         (REC_W),
      .OVERWRITE (OVERWRITE)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push      (push_c),
      .push_data (rec_c),
      .pop_ready (TR_READY),
      .out_valid (TR_VALID),
      .out_data  (head),
      .overflow  (OVERFLOW)
   );

   assign TR_KIND = head.kind;
   assign TR_PC   = head.pc;
   assign TR_ADDR = head.addr;
   assign TR_DATA = head.data;

endmodule

// File: doc/riscv_trace_monitor.md
Name: riscv_trace_monitor

Overview:
- Parametrised, synthesizable run monitor for the pipelined RISC-V core. Replaces per-cycle pipeline-register printing with a buffered commit trace.
- Sits beside the core in the testbench top. Snoops retire, register-file write and D-memory write activity.
- Captures commit records into a circular trace buffer that the bench drains through a valid/ready port.
- Counts cycles and retires, and detects end-of-test: a jump-to-self halt, or a hang timeout.

Parameters:
- DEPTH, 16: trace buffer entries; power of two, minimum 2.
- AW, $clog2(DEPTH): buffer pointer width.
- HALT_REPEAT, 3: consecutive retires at the same PC that declare a halt.
- STALL_LIMIT, 1024: cycles in S_RUN with no retire that declare a hang.
- OVERWRITE, 0: 0 drops new records when full; 1 overwrites the oldest record.
- CNT_W, 32: width of the cycle and retire counters.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- RET_VALID  in  1  one instruction retires this cycle
- RET_PC  in  32  PC of the retiring instruction
- RF_WE  in  1  register-file write enable, qualified by RET_VALID
- RF_WA  in  5  register-file write address
- RF_WD  in  32  register-file write data
- DM_WE  in  1  D-memory store accompanying the retire
- DM_ADDR  in  32  store address
- DM_DATA  in  32  store data
- TR_VALID  out  1  trace head is valid
- TR_READY  in  1  consumer accepts the head
- TR_KIND  out  2  record kind: 0 plain, 1 reg write, 2 store, 3 reg write + store
- TR_PC  out  32  PC of the head record
- TR_ADDR  out  32  {27'b0, RF_WA} for kind 1; DM_ADDR for kinds 2 and 3
- TR_DATA  out  32  RF_WD for kind 1; DM_DATA for kinds 2 and 3
- CYCLE_CNT  out  CNT_W  cycles since leaving S_IDLE
- RETIRE_CNT  out  CNT_W  retired instructions
- DONE  out  1  sticky end-of-test flag
- STATUS  out  2  0 running, 1 halt (pass), 2 hang
- OVERFLOW  out  1  sticky: at least one record was lost or overwritten

Behaviour:
- Reset: all outputs 0; pointers and counters 0; state S_IDLE. RST asserted mid-run discards all buffered records the next cycle.
- Record formation: each cycle with RET_VALID=1 forms one record. Kind is {DM_WE, RF_WE & (RF_WA!=0)}. A write to x0 is kind 0.
- Write latency: a record appears on TR_* 1 cycle after its RET_VALID when the buffer was empty. There is no combinational input-to-output path.
- Handshake: a pop occurs when TR_VALID & TR_READY on the clock edge. TR_* hold stable while TR_VALID=1 and TR_READY=0.
- Simultaneous push and pop: if the buffer is full, both succeed, occupancy is unchanged, and OVERFLOW is not set. If the buffer is empty, the pop is invalid and only the push takes effect.
- Full with push and no pop: OVERWRITE=0 drops the new record. OVERWRITE=1 advances both read and write pointers. Either case sets OVERFLOW.
- Pointers wrap modulo DEPTH. Full/empty are resolved with an extra pointer bit.
- Counters: CYCLE_CNT increments every cycle in S_RUN. RETIRE_CNT increments on each RET_VALID in S_RUN. Both saturate at all-ones and freeze in S_DONE.
- State machine:
  - S_IDLE -> S_RUN on the first RET_VALID. That retire is recorded and counted.
  - S_RUN -> S_DONE with STATUS=1 when HALT_REPEAT consecutive retires carry an identical RET_PC. The repeat counter resets on any PC change.
  - S_RUN -> S_DONE with STATUS=2 when the idle-cycle counter reaches STALL_LIMIT. The idle-cycle counter clears on each retire.
  - Halt and hang in the same cycle: halt wins.
  - S_DONE is absorbing until RST. New retires are ignored. Draining continues normally.
- DONE = (state == S_DONE), registered.

Optional Feature:
- Macro: RISCV_TRACE_FILTER_EN.
- Defined: adds input FILT_EN (1 bit). While FILT_EN=1, kind-0 records are not pushed. They are still counted in RETIRE_CNT and still evaluated for halt detection.
- Undefined: no FILT_EN port; every retire is pushed.

Decomposition:
- Shared package riscv_trace_pkg holds:
  - kind constants TK_PLAIN, TK_REG, TK_STORE, TK_BOTH;
  - status constants ST_RUN, ST_HALT, ST_HANG;
  - state encodings S_IDLE, S_RUN, S_DONE.
- One sub-module, trace_fifo: parametrised DEPTH/width circular buffer with an overwrite mode and an overflow output. The top module holds the FSM, counters and record formation.

Test Plan:
- RF write: RET_VALID with PC=0x10, RF_WE=1, WA=5, WD=0xDEADBEEF, TR_READY=1 -> next cycle TR_VALID=1, KIND=1, PC=0x10, ADDR=5, DATA=0xDEADBEEF; RETIRE_CNT=1.
- Fill and overwrite: with TR_READY=0, push DEPTH+2 records with PCs 0,4,8,... and OVERWRITE=1 -> OVERFLOW=1; the drain yields PCs 8 upward, exactly DEPTH records. With OVERWRITE=0 -> the drain yields PCs 0..4(DEPTH-1).
- Halt: 3 retires at PC=0x40 after 0x3C -> DONE=1 and STATUS=1 on the cycle after the third; later retires do not change RETIRE_CNT.
- Hang: one retire, then none for STALL_LIMIT=8 cycles -> DONE=1, STATUS=2; CYCLE_CNT frozen at 9.
- Backpressure with a full buffer: toggle TR_READY with a push every cycle -> TR_* stable while stalled; no loss and OVERFLOW=0 whenever a pop coincides with a push.
- Reset mid-run: assert RST with 5 records buffered -> next cycle TR_VALID=0, counters 0, state S_IDLE, OVERFLOW=0.
